linear_interpolator: RTL and testbench

- Interpolating counterpart to average_filter, which acts as a smoothing/decimating consumer.
- Takes a low-rate sample stream qualified by i_ce and emits 2^LOG2_R linearly interpolated samples per accepted input, each qualified by o_ce.
- Sits on the output side of the DSP chain, restoring rate after averaging/decimation.
- Unsigned data; same i_ce/data_in to data_out/o_ce stream convention as the filter blocks.

---
 rtl/dsp_pkg.sv | 23 ++
 rtl/linear_interpolator_if.sv | 23 ++
 rtl/interp_step_accumulator.sv | 59 +++++
 rtl/linear_interpolator.sv | 77 +++++++
 tb/tb_linear_interpolator.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP chain: default widths, interpolator state
// encoding and the width helpers used by the interpolator and its bench.
package dsp_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int LOG2_R_DEFAULT     = 2;
  localparam int R                  = 1 << LOG2_R_DEFAULT;
  localparam int ACC_W              = DATA_WIDTH_DEFAULT + LOG2_R_DEFAULT + 1;

  typedef enum logic {
    INTERP_IDLE = 1'b0,
    INTERP_RUN  = 1'b1
  } interp_state_e;

  function automatic int interp_r(input int log2_r);
    return 1 << log2_r;
  endfunction

  function automatic int interp_acc_w(input int data_width, input int log2_r);
    return data_width + log2_r + 1;
  endfunction

endpackage

// File: rtl/linear_interpolator_if.sv
// Sample-stream bundle of the interpolator: strobe/data in, strobe/data and
// status out.
interface linear_interpolator_if #(
  parameter int DATA_WIDTH = dsp_pkg::DATA_WIDTH_DEFAULT
);
  logic                  i_ce;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  o_ce;
  logic                  o_busy;
  logic                  o_overrun;

  modport master (
    output i_ce, data_in,
    input  o_ready, data_out, o_ce, o_busy, o_overrun
  );

  modport slave (
    input  i_ce, data_in,
    output o_ready, data_out, o_ce, o_busy, o_overrun
  );
endinterface

// File: rtl/interp_step_accumulator.sv
// Step accumulator: loads prev*R on a new sample, then adds the sample
// difference once per step and presents floor(acc / R) as the output sample.
module interp_step_accumulator
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int LOG2_R     = LOG2_R_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int AW = interp_acc_w(DATA_WIDTH, LOG2_R);

  logic        [DATA_WIDTH-1:0] prev_q, prev_d;
  logic signed [DATA_WIDTH:0]   diff_q, diff_d;
  logic signed [AW-1:0]         acc_q, acc_d;
  logic        [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    prev_d     = prev_q;
    diff_d     = diff_q;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    if (load) begin
      diff_d = $signed({1'b0, data_in}) - $signed({1'b0, prev_q});
      acc_d  = $signed({{(LOG2_R + 1){1'b0}}, prev_q}) <<< LOG2_R;
      prev_d = data_in;
    end else if (step) begin
      acc_d = acc_q + $signed({{LOG2_R{diff_q[DATA_WIDTH]}}, diff_q});
    end
    // acc never goes negative and stays below 2^DATA_WIDTH * R, so the
    // slice equals the arithmetic shift (floor) without saturation.
    if (load || step) begin
      data_out_d = acc_d[LOG2_R +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      diff_q     <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
    end else begin
      prev_q     <= prev_d;
      diff_q     <= diff_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: rtl/linear_interpolator.sv
// Linear interpolator: each accepted sample produces R output samples ramping
// from the previous sample toward the new one.
module linear_interpolator
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int LOG2_R     = LOG2_R_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  linear_interpolator_if.slave bus
);

  localparam int                RATE       = interp_r(LOG2_R);
  localparam logic [LOG2_R-1:0] PHASE_LAST = LOG2_R'(RATE - 1);

  interp_state_e     state_q, state_d;
  logic [LOG2_R-1:0] phase_q, phase_d;
  logic              o_ce_q, o_ce_d;
  logic              o_overrun_q, o_overrun_d;
  logic              ready, accept, step;

  // The first sample of a burst is emitted on the acceptance edge itself, so
  // the last RUN phase only holds the final sample and can accept the next one.
  always_comb begin
    ready       = (state_q == INTERP_IDLE) || (phase_q == PHASE_LAST);
    accept      = bus.i_ce && ready;
    step        = (state_q == INTERP_RUN) && (phase_q != PHASE_LAST);
    state_d     = state_q;
    phase_d     = phase_q;
    if (accept) begin
      state_d = INTERP_RUN;
      phase_d = '0;
    end else if (state_q == INTERP_RUN) begin
      if (phase_q == PHASE_LAST) begin
        state_d = INTERP_IDLE;
        phase_d = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
    o_ce_d      = accept || step;
    o_overrun_d = bus.i_ce && !ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INTERP_IDLE;
      phase_q     <= '0;
      o_ce_q      <= 1'b0;
      o_overrun_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      o_ce_q      <= o_ce_d;
      o_overrun_q <= o_overrun_d;
    end
  end

  interp_step_accumulator #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_R     (LOG2_R)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (step),
    .data_in  (bus.data_in),
    .data_out (bus.data_out)
  );

  assign bus.o_ready   = ready;
  assign bus.o_ce      = o_ce_q;
  assign bus.o_busy    = (state_q == INTERP_RUN);
  assign bus.o_overrun = o_overrun_q;

endmodule

// File: tb/tb_linear_interpolator.sv
// Bench for linear_interpolator: directed scenarios plus random traffic
// checked against a queue-based model of the interpolation rules.
module tb_linear_interpolator;
  import dsp_pkg::*;

  localparam int DW   = 8;
  localparam int L2R  = 2;
  localparam int RF   = 1 << L2R;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  linear_interpolator_if #(.DATA_WIDTH(DW)) bus ();

  linear_interpolator #(
    .DATA_WIDTH (DW),
    .LOG2_R     (L2R)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  int m_prev;
  int m_q[$];
  int m_dout;
  bit m_ce, m_busy, m_ovr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_prev = 0;
    m_dout = 0;
    m_ce   = 0;
    m_busy = 0;
    m_ovr  = 0;
  endtask

  // One clock: drive inputs, check o_ready, clock, advance model, check outputs.
  task automatic cycle(input bit ice, input int d, input bit rst);
    bit rdy_m;
    bus.i_ce    = ice;
    bus.data_in = d[DW-1:0];
    reset       = rst;
    rdy_m       = (m_q.size() == 0);
    #1;
    check_val("o_ready", {31'd0, bus.o_ready}, {31'd0, rdy_m});
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_ovr = ice && !rdy_m;
      if (ice && rdy_m) begin
        for (int k = 0; k < RF; k++)
          m_q.push_back(floor_div(m_prev * RF + k * (d - m_prev), RF));
        m_prev = d;
      end
      if (m_q.size() > 0) begin
        m_dout = m_q.pop_front();
        m_ce   = 1;
        m_busy = 1;
      end else begin
        m_ce   = 0;
        m_busy = 0;
      end
    end
    #1;
    check_val("o_ce",      {31'd0, bus.o_ce},      {31'd0, m_ce});
    check_val("o_busy",    {31'd0, bus.o_busy},    {31'd0, m_busy});
    check_val("o_overrun", {31'd0, bus.o_overrun}, {31'd0, m_ovr});
    check_val("data_out",  {24'd0, bus.data_out},  m_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, int'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    bus.i_ce    = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    cycle(1'b0, 0, 1'b1);
    idle(1);

    // First sample from reset, then a falling step
    cycle(1'b1, 100, 1'b0);
    idle(4);
    cycle(1'b1, 20, 1'b0);
    idle(5);

    // Full-scale rise from zero
    cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 255, 1'b0);
    idle(5);

    // Floor on a small decreasing step
    cycle(1'b1, 10, 1'b0);
    idle(4);
    cycle(1'b1, 7, 1'b0);
    idle(5);

    // Back-to-back bursts on the last phase
    cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 40, 1'b0);
    idle(3);
    cycle(1'b1, 80, 1'b0);
    idle(5);

    // Overrun mid-burst: sample dropped
    cycle(1'b1, 50, 1'b0);
    idle(1);
    cycle(1'b1, 200, 1'b0);
    idle(4);

    // Reset in the middle of a burst, then restart
    cycle(1'b1, 60, 1'b0);
    idle(1);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 8, 1'b0);
    idle(5);

    // Reset and i_ce together: reset wins
    cycle(1'b1, 99, 1'b1);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int  d;
      bit  ice;
      bit  rst;
      case ($urandom_range(0, 9))
        0:       d = 0;
        1:       d = 255;
        default: d = int'($urandom_range(0, 255));
      endcase
      ice = ($urandom_range(0, 99) < 45);
      rst = ($urandom_range(0, 99) < 2);
      cycle(ice, d, rst);
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
